// File: rtl/cfg_pkg.sv
// Shared constants and state type for the per-tile configuration loader.
package cfg_pkg;
    localparam int             PROG_W    = 69;
    localparam int             CRC_W     = 8;
    localparam logic [7:0]     CRC_POLY  = 8'h07;
    localparam int             FRAME_LEN = PROG_W + CRC_W;

    localparam int LUT_LSB = 52;
    localparam int SB_LSB  = 20;
    localparam int SEL_LSB = 8;
    localparam int IO_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } cfg_state_t;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC register, MSB-first, zero init, no reflection or final XOR.
module crc8_serial #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = 8'h07
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] crc
);
    logic fb;

    assign fb = crc[W-1] ^ bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= {crc[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader: shifts a CRC-protected frame into a shadow
// register and commits it to prog only when the received CRC matches.
//
// state | meaning
// IDLE  | waiting for cfg_start, link not ready
// SHIFT | accepting data bits then CRC bits
// CHECK | one-cycle commit / discard decision
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int                 PROG_W   = cfg_pkg::PROG_W,
    parameter int                 CRC_W    = cfg_pkg::CRC_W,
    parameter logic [CRC_W-1:0]   CRC_POLY = cfg_pkg::CRC_POLY
) (
    input  logic              clb_clk,
    input  logic              clb_rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_data,
    output logic              cfg_ready,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [PROG_W-1:0] prog
);
    localparam logic [6:0] DATA_N     = 7'(PROG_W);
    localparam logic [6:0] FRAME_LAST = 7'(PROG_W + CRC_W - 1);

    cfg_state_t         state;
    logic [6:0]         cnt;
    logic [PROG_W-1:0]  shadow;
    logic [CRC_W-1:0]   rx_crc;
    logic [CRC_W-1:0]   run_crc;
    logic               crc_clr;
    logic               crc_en;

    // A start pulse during CHECK must not disturb the pending compare.
    assign crc_clr = cfg_start && (state != CHECK);
    assign crc_en  = (state == SHIFT) && cfg_valid && !cfg_start && (cnt < DATA_N);

    assign cfg_ready = (state == SHIFT);
    assign busy      = (state != IDLE);

    crc8_serial #(
        .W    (CRC_W),
        .POLY (CRC_POLY)
    ) u_crc (
        .clk    (clb_clk),
        .rst    (clb_rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (cfg_data),
        .crc    (run_crc)
    );

    always_ff @(posedge clb_clk or posedge clb_rst) begin
        if (clb_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            rx_crc   <= '0;
            prog     <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        shadow <= '0;
                        rx_crc <= '0;
                    end
                end
                SHIFT: begin
                    if (cfg_start) begin
                        cnt    <= '0;
                        shadow <= '0;
                        rx_crc <= '0;
                    end else if (cfg_valid) begin
                        if (cnt < DATA_N)
                            shadow <= {shadow[PROG_W-2:0], cfg_data};
                        else
                            rx_crc <= {rx_crc[CRC_W-2:0], cfg_data};
                        cnt <= cnt + 7'd1;
                        if (cnt == FRAME_LAST)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    if (run_crc == rx_crc) begin
                        prog     <= shadow;
                        cfg_done <= 1'b1;
                    end else begin
                        cfg_err  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: fixed frame table, hand sequences for abort/reset,
// and random frames checked against a polynomial-division CRC model.
module tb_cfg_loader;
    import cfg_pkg::*;

    logic              clb_clk = 1'b0;
    logic              clb_rst;
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_data;
    logic              cfg_ready;
    logic              busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [68:0]       prog;

    int n_pass  = 0;
    int n_total = 0;
    bit both_seen = 0;

    typedef struct {
        logic [68:0] d;
        logic [7:0]  c;
        bit          ed;
        bit          ee;
        logic [68:0] ep;
    } vec_t;

    vec_t tbl [5];

    cfg_loader dut (
        .clb_clk   (clb_clk),
        .clb_rst   (clb_rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .prog      (prog)
    );

    always #5 clb_clk = ~clb_clk;

    always @(negedge clb_clk)
        if (cfg_done && cfg_err) both_seen = 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Remainder of {data, 8'b0} divided by x^8+x^2+x+1 over GF(2).
    function automatic logic [7:0] crc_ref(input logic [68:0] d);
        logic [76:0] r;
        r = {d, 8'h00};
        for (int i = 76; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clb_clk);
        #1;
    endtask

    task automatic send_frame(input string name, input logic [68:0] d, input logic [7:0] c,
                              input int gap, input bit start_in_check,
                              input bit ed, input bit ee, input logic [68:0] ep);
        bit rdy_ok;
        bit early;
        bit v;
        bit bv;
        int tries;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 1'($urandom_range(1));
        tick();
        cfg_start = 1'b0;
        check({name, " ready after start"}, 69'(cfg_ready), 69'd1);
        rdy_ok = 1;
        early  = 0;
        for (int b = 0; b < 77; b++) begin
            bv = (b < 69) ? d[68-b] : c[7-(b-69)];
            tries = 0;
            do begin
                v = (gap == 0 || tries >= 16) ? 1'b1 : ($urandom_range(99) >= gap);
                cfg_valid = v;
                cfg_data  = v ? bv : 1'($urandom_range(1));
                if (!cfg_ready) rdy_ok = 0;
                if (cfg_done || cfg_err) early = 1;
                tick();
                tries++;
            end while (!v);
        end
        cfg_valid = 1'b0;
        cfg_start = start_in_check;
        check({name, " ready during shift"}, 69'(rdy_ok), 69'd1);
        check({name, " no pulse during shift"}, 69'(early), 69'd0);
        check({name, " ready in check"}, 69'(cfg_ready), 69'd0);
        check({name, " busy in check"}, 69'(busy), 69'd1);
        tick();
        cfg_start = 1'b0;
        check({name, " done"}, 69'(cfg_done), 69'(ed));
        check({name, " err"}, 69'(cfg_err), 69'(ee));
        check({name, " prog"}, prog, ep);
        tick();
        check({name, " pulses cleared"}, 69'({cfg_done, cfg_err}), 69'd0);
        check({name, " idle after"}, 69'({busy, cfg_ready}), 69'd0);
    endtask

    initial begin
        logic [68:0] model_prog;
        logic [68:0] d;
        logic [7:0]  c;
        bit          bad;

        tbl[0] = '{69'h0, 8'h00, 1, 0, 69'h0};
        tbl[1] = '{69'h1, 8'h07, 1, 0, 69'h1};
        tbl[2] = '{69'h2, 8'h0E, 1, 0, 69'h2};
        tbl[3] = '{69'h1, 8'h07, 1, 0, 69'h1};
        tbl[4] = '{69'h2, 8'h0F, 0, 1, 69'h1};

        clb_rst   = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        #3;
        check("reset prog", prog, 69'h0);
        check("reset outputs", 69'({cfg_ready, busy, cfg_done, cfg_err}), 69'd0);
        #9 clb_rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            send_frame($sformatf("table%0d", i), tbl[i].d, tbl[i].c, 0, 0,
                       tbl[i].ed, tbl[i].ee, tbl[i].ep);

        // Abort after 40 bits, then a clean frame.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 1'($urandom_range(1));
            tick();
        end
        check("abort no done", 69'(cfg_done), 69'd0);
        send_frame("abort", 69'h2, 8'h0E, 0, 0, 1, 0, 69'h2);

        send_frame("gaps", 69'h1, 8'h07, 50, 0, 1, 0, 69'h1);
        send_frame("start_in_check", 69'h2, 8'h0E, 0, 1, 1, 0, 69'h2);

        // Asynchronous reset at transfer 30.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 1'($urandom_range(1));
            tick();
        end
        cfg_valid = 1'b0;
        #2 clb_rst = 1'b1;
        #1;
        check("midreset prog", prog, 69'h0);
        check("midreset busy/ready", 69'({busy, cfg_ready}), 69'd0);
        #2 clb_rst = 1'b0;
        tick();
        d = {5'($urandom), $urandom, $urandom};
        send_frame("after reset", d, crc_ref(d), 30, 0, 1, 0, d);
        model_prog = d;

        for (int i = 0; i < 12; i++) begin
            d   = {5'($urandom), $urandom, $urandom};
            bad = ($urandom_range(3) == 0);
            c   = crc_ref(d) ^ (bad ? 8'($urandom_range(255, 1)) : 8'h00);
            if (!bad) model_prog = d;
            send_frame($sformatf("rand%0d", i), d, c, $urandom_range(60), 0,
                       !bad, bad, model_prog);
        end

        check("done and err never together", 69'(both_seen), 69'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
